// File: rtl/l2_window_skew_feeder_pkg.sv
// Shared definitions for the layer-2 window feeder: parameter defaults,
// window-count derivation, FSM state type and the pixel-offset helper.
// Takes over the role of the former l2_feeder_defs.vh header.
package l2_window_skew_feeder_pkg;

  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned IMG_DEF      = 4;
  localparam int unsigned STRIDE_DEF   = 2;
  localparam int unsigned LAG_DEF      = 1;
  localparam int unsigned PATH_LAT_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feederState_e;

  // Windows per row/column of the feature map.
  function automatic int unsigned winSide(input int unsigned img, input int unsigned stride);
    return (img - 2) / stride + 1;
  endfunction

  // Total number of 2x2 windows.
  function automatic int unsigned winCount(input int unsigned img, input int unsigned stride);
    int unsigned side;
    side = winSide(img, stride);
    return side * side;
  endfunction

  // Width of a window index; never zero so a single window still has a port.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of pixel (r,c) in the flattened map; r0c0 sits in the MSBs.
  function automatic int pixOffset(input int r, input int c, input int img, input int dw);
    return dw * (img * img - 1 - (r * img + c));
  endfunction

endpackage

// File: rtl/l2_window_skew_feeder_if.sv
// Handshake/data bundle between the feeder and its host. The host side
// (start, feature map, kernel) is the master; the feeder is the slave.
interface l2_window_skew_feeder_if
  import l2_window_skew_feeder_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned IMG    = IMG_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
);

  localparam int unsigned NWIN = winCount(IMG, STRIDE);
  localparam int unsigned IDXW = idxWidth(NWIN);

  logic                  start;
  logic [IMG*IMG*DW-1:0] fmap_in;
  logic [4*DW-1:0]       kern_in;

  logic [DW-1:0]         k_in1;
  logic [DW-1:0]         k_in3;
  logic [DW-1:0]         k_in5;
  logic [DW-1:0]         k_in7;
  logic [DW-1:0]         px_in2;
  logic [DW-1:0]         px_in4;
  logic [DW-1:0]         px_in6;
  logic [DW-1:0]         px_in8;
  logic                  busy;
  logic                  res_valid;
  logic [IDXW-1:0]       res_idx;
  logic                  done;

  modport master (
    output start, fmap_in, kern_in,
    input  k_in1, k_in3, k_in5, k_in7,
    input  px_in2, px_in4, px_in6, px_in8,
    input  busy, res_valid, res_idx, done
  );

  modport slave (
    input  start, fmap_in, kern_in,
    output k_in1, k_in3, k_in5, k_in7,
    output px_in2, px_in4, px_in6, px_in8,
    output busy, res_valid, res_idx, done
  );

endinterface

// File: rtl/l2_valid_delay.sv
// Fixed-latency {valid, idx} delay line predicting when each window result
// leaves the conv array. Asynchronous reset flushes every stage.
module l2_valid_delay #(
  parameter int unsigned PATH_LAT = 6,
  parameter int unsigned IDXW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validIn,
  input  logic [IDXW-1:0] idxIn,
  output logic            validOut,
  output logic [IDXW-1:0] idxOut
);

  logic [PATH_LAT-1:0] vldPipe;
  logic [IDXW-1:0]     idxPipe [PATH_LAT];

  // Shift valid and index one stage per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vldPipe <= '0;
      for (int unsigned i = 0; i < PATH_LAT; i++) begin
        idxPipe[i] <= '0;
      end
    end else begin
      vldPipe[0] <= validIn;
      idxPipe[0] <= idxIn;
      for (int unsigned i = 1; i < PATH_LAT; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        idxPipe[i] <= idxPipe[i-1];
      end
    end
  end

  assign validOut = vldPipe[PATH_LAT-1];
  assign idxOut   = idxPipe[PATH_LAT-1];

endmodule

// File: rtl/l2_window_skew_feeder.sv
// Layer-2 feeder for the 2x2 stride-2 conv tree: latches a feature map and
// kernel on start, walks the windows in raster order and drives the eight
// tree input lanes, predicting when each window result leaves the array.
// Build option L2_FEEDER_SKEW_EN: top-left/bottom-left lanes (IN2/IN6) trail
// the right-hand lanes by LAG steps; without it all four pixel lanes carry
// the same window each step.
module l2_window_skew_feeder
  import l2_window_skew_feeder_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned IMG      = IMG_DEF,
  parameter int unsigned STRIDE   = STRIDE_DEF,
  parameter int unsigned LAG      = LAG_DEF,
  parameter int unsigned PATH_LAT = PATH_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  l2_window_skew_feeder_if.slave bus
);

  localparam int unsigned SIDE = winSide(IMG, STRIDE);
  localparam int unsigned NWIN = winCount(IMG, STRIDE);
  localparam int unsigned IDXW = idxWidth(NWIN);
  localparam int unsigned FMW  = IMG * IMG * DW;
`ifdef L2_FEEDER_SKEW_EN
  localparam int unsigned SKEW = LAG;
`else
  // Balanced tree build: LAG has no effect.
  localparam int unsigned SKEW = 0 * LAG;
`endif
  localparam int unsigned NISSUE = NWIN + SKEW;
  localparam int unsigned STEPW  = $clog2(NISSUE + 1);

  feederState_e    state;
  feederState_e    stateNext;
  logic [FMW-1:0]  fmapQ;
  logic [STEPW-1:0] stepCnt;

  logic [FMW-1:0]  fmapSrc;
  int              stepI;
  int              lagW;
  logic [DW-1:0]   leadTR;
  logic [DW-1:0]   leadBR;
  logic [DW-1:0]   lagTL;
  logic [DW-1:0]   lagBL;
  logic            lagOk;
  logic [IDXW-1:0] lagIdx;
  logic            accept;
  logic            issueNext;

  logic            lagValid;
  logic [IDXW-1:0] lagIdxQ;
  logic            resValid;
  logic [IDXW-1:0] resIdx;

  // Pixel (dr,dc) of window win, taken from a flattened map.
  function automatic logic [DW-1:0] pixAt(input logic [FMW-1:0] fm, input int win,
                                          input int dr, input int dc);
    int r;
    int c;
    r = int'(STRIDE) * (win / int'(SIDE)) + dr;
    c = int'(STRIDE) * (win % int'(SIDE)) + dc;
    return fm[pixOffset(r, c, int'(IMG), int'(DW)) +: DW];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = ISSUE;
      ISSUE:   if (int'(stepCnt) == int'(NISSUE) - 1) stateNext = DRAIN;
      DRAIN:   if (resValid && int'(resIdx) == int'(NWIN) - 1) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Lane values for the step about to be presented. Step 0 is loaded on the
  // accepting edge straight from fmap_in so that lanes are live the first
  // cycle after start; later steps come from the latched copy.
  always_comb begin
    accept    = (state == IDLE) && (stateNext == ISSUE);
    issueNext = (stateNext == ISSUE);
    fmapSrc   = fmapQ;
    stepI     = int'(stepCnt) + 1;
    if (state == IDLE) begin
      fmapSrc = bus.fmap_in;
      stepI   = 0;
    end
    lagW   = stepI - int'(SKEW);
    leadTR = '0;
    leadBR = '0;
    lagTL  = '0;
    lagBL  = '0;
    lagOk  = 1'b0;
    lagIdx = '0;
    if (stepI < int'(NWIN)) begin
      leadTR = pixAt(fmapSrc, stepI, 0, 1);
      leadBR = pixAt(fmapSrc, stepI, 1, 1);
    end
    if (lagW >= 0 && lagW < int'(NWIN)) begin
      lagOk  = 1'b1;
      lagTL  = pixAt(fmapSrc, lagW, 0, 0);
      lagBL  = pixAt(fmapSrc, lagW, 1, 0);
      lagIdx = IDXW'(lagW);
    end
  end

  // Registered outputs, step counter and latched operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmapQ      <= '0;
      stepCnt    <= '0;
      bus.k_in1  <= '0;
      bus.k_in3  <= '0;
      bus.k_in5  <= '0;
      bus.k_in7  <= '0;
      bus.px_in2 <= '0;
      bus.px_in4 <= '0;
      bus.px_in6 <= '0;
      bus.px_in8 <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      lagValid   <= 1'b0;
      lagIdxQ    <= '0;
    end else begin
      if (accept) begin
        fmapQ     <= bus.fmap_in;
        bus.k_in1 <= bus.kern_in[4*DW-1 -: DW];
        bus.k_in3 <= bus.kern_in[3*DW-1 -: DW];
        bus.k_in5 <= bus.kern_in[2*DW-1 -: DW];
        bus.k_in7 <= bus.kern_in[DW-1:0];
      end else if (stateNext == IDLE) begin
        bus.k_in1 <= '0;
        bus.k_in3 <= '0;
        bus.k_in5 <= '0;
        bus.k_in7 <= '0;
      end
      stepCnt    <= issueNext ? STEPW'(stepI) : '0;
      bus.px_in4 <= issueNext ? leadTR : '0;
      bus.px_in8 <= issueNext ? leadBR : '0;
      bus.px_in2 <= issueNext ? lagTL : '0;
      bus.px_in6 <= issueNext ? lagBL : '0;
      lagValid   <= issueNext && lagOk;
      lagIdxQ    <= (issueNext && lagOk) ? lagIdx : '0;
      bus.busy   <= (stateNext != IDLE);
      bus.done   <= (stateNext == DONE);
    end
  end

  // lagValid marks the cycle a window is complete on all lanes; the result
  // follows PATH_LAT cycles later.
  l2_valid_delay #(
    .PATH_LAT(PATH_LAT),
    .IDXW    (IDXW)
  ) uDelay (
    .clk     (clk),
    .rst     (rst),
    .validIn (lagValid),
    .idxIn   (lagIdxQ),
    .validOut(resValid),
    .idxOut  (resIdx)
  );

  assign bus.res_valid = resValid;
  assign bus.res_idx   = resIdx;

endmodule

// File: tb/tb_l2_window_skew_feeder.sv
// Bench for l2_window_skew_feeder: per-step expectation table plus a result
// scoreboard; follows L2_FEEDER_SKEW_EN the same way the design does.
module tb_l2_window_skew_feeder;

  localparam int unsigned DW       = 16;
  localparam int unsigned IMG      = 4;
  localparam int unsigned STRIDE   = 2;
  localparam int unsigned LAG      = 1;
  localparam int unsigned PATH_LAT = 6;
`ifdef L2_FEEDER_SKEW_EN
  localparam int SKEW = int'(LAG);
`else
  localparam int SKEW = 0;
`endif
  localparam int NWIN      = 4;
  localparam int NISSUE    = NWIN + SKEW;
  localparam int RES0      = SKEW + int'(PATH_LAT);
  localparam int DONE_STEP = RES0 + NWIN;
  localparam int NSTEP     = DONE_STEP + 4;

  typedef struct packed {
    logic [DW-1:0] k1, k3, k5, k7;
    logic [DW-1:0] p2, p4, p6, p8;
    logic          busy;
    logic          rv;
    logic [1:0]    idx;
    logic          done;
  } outs_t;

  typedef struct {
    logic  startIn;
    outs_t exp;
  } vec_t;

  typedef struct {
    int idx;
    int step;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_window_skew_feeder_if #(.DW(DW), .IMG(IMG), .STRIDE(STRIDE)) bus();

  l2_window_skew_feeder #(
    .DW(DW), .IMG(IMG), .STRIDE(STRIDE), .LAG(LAG), .PATH_LAT(PATH_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nTests = 0;
  int nFail  = 0;
  vec_t vecs [16];
  sb_t  sbQ [$];
  bit   monOn = 1'b0;
  int   curStep = 0;
  logic [IMG*IMG*DW-1:0] fmapV;
  logic [4*DW-1:0]       kernV;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pix(input int r, input int c);
    return 156 + 36 * (r + c);
  endfunction

  function automatic outs_t expAt(input int s);
    outs_t o;
    int lw;
    o = '0;
    o.busy = (s <= DONE_STEP);
    if (o.busy) begin
      o.k1 = 16'd2; o.k3 = 16'd3; o.k5 = 16'd3; o.k7 = 16'd4;
    end
    if (s < NISSUE && s < NWIN) begin
      o.p4 = 16'(pix(2 * (s / 2), 2 * (s % 2) + 1));
      o.p8 = 16'(pix(2 * (s / 2) + 1, 2 * (s % 2) + 1));
    end
    lw = s - SKEW;
    if (s < NISSUE && lw >= 0 && lw < NWIN) begin
      o.p2 = 16'(pix(2 * (lw / 2), 2 * (lw % 2)));
      o.p6 = 16'(pix(2 * (lw / 2) + 1, 2 * (lw % 2)));
    end
    if (s >= RES0 && s < RES0 + NWIN) begin
      o.rv  = 1'b1;
      o.idx = 2'(s - RES0);
    end
    o.done = (s == DONE_STEP);
    return o;
  endfunction

  function automatic outs_t sampleOuts();
    outs_t o;
    o.k1 = bus.k_in1;  o.k3 = bus.k_in3;  o.k5 = bus.k_in5;  o.k7 = bus.k_in7;
    o.p2 = bus.px_in2; o.p4 = bus.px_in4; o.p6 = bus.px_in6; o.p8 = bus.px_in8;
    o.busy = bus.busy; o.rv = bus.res_valid; o.idx = bus.res_idx; o.done = bus.done;
    return o;
  endfunction

  function automatic logic [63:0] pxLanes();
    return {bus.px_in2, bus.px_in4, bus.px_in6, bus.px_in8};
  endfunction

  // Scoreboard: every res_valid must match the next queued {idx, step}.
  always @(negedge clk) begin
    if (monOn && bus.res_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL sb_unexpected: res_valid at step %0d idx %0d, required none", curStep, bus.res_idx);
      end else begin
        sb_t e;
        e = sbQ.pop_front();
        check("sb_result", {bus.res_idx, curStep}, {2'(e.idx), e.step});
      end
    end
  end

  // Start one job and compare the table through step stopAfter.
  task automatic runSeq(input int stopAfter, input bit litOn);
    outs_t act;
    @(negedge clk);
    bus.fmap_in = fmapV;
    bus.kern_in = kernV;
    bus.start   = 1'b1;
    for (int w = 0; w < NWIN; w++) sbQ.push_back('{idx: w, step: RES0 + w});
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.fmap_in = ~fmapV;
    bus.kern_in = ~kernV;
    curStep     = 0;
    monOn       = 1'b1;
    for (int s = 0; s <= stopAfter; s++) begin
      @(negedge clk);
      act = sampleOuts();
      if (!vecs[s].exp.rv) act.idx = '0;
      check($sformatf("step%0d", s), 256'(act), 256'(vecs[s].exp));
      if (litOn) begin
`ifdef L2_FEEDER_SKEW_EN
        if (s == 0) check("lit_step0", pxLanes(), {16'd0, 16'd192, 16'd0, 16'd228});
        if (s == 1) check("lit_step1", pxLanes(), {16'd156, 16'd264, 16'd192, 16'd300});
        if (s == 4) check("lit_step4", pxLanes(), {16'd300, 16'd0, 16'd336, 16'd0});
`else
        if (s == 0) check("lit_step0", pxLanes(), {16'd156, 16'd192, 16'd192, 16'd228});
        if (s == 3) check("lit_step3", pxLanes(), {16'd300, 16'd336, 16'd336, 16'd372});
`endif
      end
      if (s == stopAfter) break;
      @(posedge clk);
      #1;
      curStep   = s + 1;
      bus.start = vecs[s + 1].startIn;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        fmapV[DW * (15 - (r * 4 + c)) +: DW] = 16'(pix(r, c));
    kernV = {16'd2, 16'd3, 16'd3, 16'd4};
    for (int s = 0; s < 16; s++) begin
      vecs[s].startIn = 1'b0;
      vecs[s].exp     = expAt(s);
    end

    rst = 1'b1;
    bus.start = 1'b0;
    bus.fmap_in = '0;
    bus.kern_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 256'(sampleOuts()), '0);
    rst = 1'b0;

    // Basic job.
    runSeq(NSTEP - 1, 1'b1);
    check("sb_drained_1", sbQ.size(), 0);

    // Start during ISSUE and on the done cycle must be ignored.
    vecs[2].startIn = 1'b1;
    vecs[DONE_STEP].startIn = 1'b1;
    runSeq(NSTEP - 1, 1'b0);
    vecs[2].startIn = 1'b0;
    vecs[DONE_STEP].startIn = 1'b0;
    check("sb_drained_2", sbQ.size(), 0);

    // Reset in the middle of step 2.
    runSeq(2, 1'b0);
    #1;
    rst = 1'b1;
    sbQ.delete();
    #1;
    check("rst_midop", 256'(sampleOuts()), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NSTEP; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {bus.busy, bus.res_valid, bus.done}, '0);
    end

    // Fresh job after reset must match the basic job exactly.
    runSeq(NSTEP - 1, 1'b1);
    check("sb_drained_3", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
